// File: rtl/btn_interface.sv
// rtl/btn_interface.sv - push-button synchronizer, debouncer and press/release tick generator
module btn_interface #(
   parameter int DEBOUNCE_CYCLES = 1_200_000,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_tick,
   output logic btn_pressed,
   output logic btn_release
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          REL_LVL  = (ACTIVE_LOW != 0);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   state_q, state_d;
   logic                   pressed_q, pressed_d;
   logic                   tick_q, tick_d;
   logic                   release_q, release_d;
   logic                   p;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
      p         = sync_q[SYNC_STAGES-1] ^ REL_LVL;
      state_d   = state_q;
      cnt_d     = '0;
      // Any cycle where p agrees with the stable state restarts the window.
      if (p != state_q) begin
         if (cnt_q == CNT_LAST) begin
            state_d = p;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      pressed_d = state_q;
      tick_d    = state_q & ~pressed_q;
      release_d = ~state_q & pressed_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= {SYNC_STAGES{REL_LVL}};
         cnt_q     <= '0;
         state_q   <= 1'b0;
         pressed_q <= 1'b0;
         tick_q    <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         pressed_q <= pressed_d;
         tick_q    <= tick_d;
         release_q <= release_d;
      end
   end

   assign btn_tick    = tick_q;
   assign btn_pressed = pressed_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_btn_interface.sv
// tb/tb_btn_interface.sv - scoreboard bench for btn_interface with short debounce window
module tb_btn_interface;

   localparam int DEB  = 16;
   localparam int SYNC = 2;
   localparam int LAT  = SYNC + DEB + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b1;
   logic btn_tick, btn_pressed, btn_release;

   btn_interface #(
      .DEBOUNCE_CYCLES(DEB),
      .SYNC_STAGES    (SYNC),
      .ACTIVE_LOW     (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_tick   (btn_tick),
      .btn_pressed(btn_pressed),
      .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit    is_tick;
      int    at;
      string name;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Expected pulse: btn_in changes at a falling edge, pulse visible LAT rising edges later.
   task automatic expect_ev(input bit is_tick, input string name);
      ev_t e;
      e.is_tick = is_tick;
      e.at      = cyc + LAT;
      e.name    = name;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic v, input int n);
      btn_in = v;
      repeat (n) @(negedge clk);
   endtask

   bit prev_tick = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      if (btn_tick && btn_release) check("tick_and_release_together", 1, 0);
      if (btn_tick && prev_tick) check("tick_back_to_back", 1, 0);
      prev_tick <= btn_tick;
      if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
         e = exp_q.pop_front();
         check({e.name, "_missed_at_cycle"}, cyc, e.at);
      end
      if (btn_tick || btn_release) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event_kind", btn_tick ? 1 : 2, 0);
         end else begin
            e = exp_q.pop_front();
            check({e.name, "_kind"}, int'(btn_tick), int'(e.is_tick));
            check({e.name, "_cycle"}, cyc, e.at);
            check({e.name, "_level"}, int'(btn_pressed), int'(e.is_tick));
         end
      end
   end

   initial begin
      rst    = 1'b1;
      btn_in = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_tick", int'(btn_tick), 0);
      check("reset_pressed", int'(btn_pressed), 0);
      check("reset_release", int'(btn_release), 0);

      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("idle_pressed", int'(btn_pressed), 0);

      hold(1'b0, 3);
      hold(1'b1, 4);
      hold(1'b0, 7);
      hold(1'b1, 5);
      hold(1'b0, 15);
      hold(1'b1, 40);
      check("bounce_pressed", int'(btn_pressed), 0);

      expect_ev(1'b1, "press");
      hold(1'b0, 200);
      check("held_pressed", int'(btn_pressed), 1);
      check("held_release", int'(btn_release), 0);

      expect_ev(1'b0, "release");
      hold(1'b1, 60);
      check("released_pressed", int'(btn_pressed), 0);

      hold(1'b0, 10);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_mid_tick", int'(btn_tick), 0);
         check("rst_mid_pressed", int'(btn_pressed), 0);
      end
      rst = 1'b0;
      expect_ev(1'b1, "post_rst_press");
      hold(1'b0, 60);
      check("post_rst_pressed", int'(btn_pressed), 1);

      hold(1'b1, 15);
      hold(1'b0, 30);
      check("release_glitch_pressed", int'(btn_pressed), 1);

      expect_ev(1'b0, "final_release");
      hold(1'b1, 60);
      check("final_pressed", int'(btn_pressed), 0);

      repeat (5) @(negedge clk);
      check("events_left", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
